// File: rtl/awg_pkg.sv
// rtl/awg_pkg.sv - shared types and latency constants for the AWG DDS front end
// Contents: state_t (sequencer states), ROM_LATENCY (rom_addr -> rom_data),
//           OUT_LATENCY (start edge -> first dout_valid, in cycles).
package awg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int ROM_LATENCY = 1;
  localparam int OUT_LATENCY = 3;

endpackage

// File: rtl/awg_amp_scale.sv
// rtl/awg_amp_scale.sv - registered signed sample x unsigned amplitude scaler
// Ports: clk_i, rst_n_i (sync, active-low)
//        data_i/valid_i : signed sample in with qualifier
//        amp_i          : unsigned amplitude word
//        data_o/valid_o : scaled sample out, one cycle later
module awg_amp_scale #(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_AMP_WIDTH  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [P_DATA_WIDTH-1:0] data_i,
  input  logic                    valid_i,
  input  logic [P_AMP_WIDTH-1:0]  amp_i,
  output logic [P_DATA_WIDTH-1:0] data_o,
  output logic                    valid_o
);

  // Amplitude is zero-extended so the multiply stays signed; the product
  // needs P_DATA_WIDTH + P_AMP_WIDTH + 1 bits.
  logic signed [P_DATA_WIDTH+P_AMP_WIDTH:0] prod;
  logic        [P_DATA_WIDTH-1:0]           data_d;
  logic                                     unused_prod_bits;

  assign prod = $signed(data_i) * $signed({1'b0, amp_i});

  // Taking bits above P_AMP_WIDTH is an arithmetic shift right (floor)
  // followed by truncation back to the sample width.
  assign data_d           = prod[P_AMP_WIDTH +: P_DATA_WIDTH];
  assign unused_prod_bits = ^{prod[P_DATA_WIDTH+P_AMP_WIDTH], prod[P_AMP_WIDTH-1:0]};

  logic [P_DATA_WIDTH-1:0] data_q;
  logic                    valid_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        data_q <= data_d;
      end
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/awg_dds_phase_gen.sv
// rtl/awg_dds_phase_gen.sv - DDS phase accumulator, ROM addressing and scaled sample stream
// Ports: clk, rst_n (sync, active-low)
//        cfg_ftw/cfg_pofs/cfg_amp/cfg_burst_len : configuration, latched on start
//        start (IDLE only), stop (RUN only)     : control
//        busy, done                             : status; done marks the last sample
//        rom_addr -> rom_data                   : external registered waveform ROM
//        dout/dout_valid                        : scaled sample stream toward the DAC
module awg_dds_phase_gen
  import awg_pkg::*;
#(
  parameter int P_PHASE_WIDTH = 32,
  parameter int P_ADDR_WIDTH  = 8,
  parameter int P_DATA_WIDTH  = 8,
  parameter int P_AMP_WIDTH   = 8,
  parameter int P_BURST_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [P_PHASE_WIDTH-1:0] cfg_ftw,
  input  logic [P_PHASE_WIDTH-1:0] cfg_pofs,
  input  logic [P_AMP_WIDTH-1:0]   cfg_amp,
  input  logic [P_BURST_WIDTH-1:0] cfg_burst_len,
  input  logic                     start,
  input  logic                     stop,
  output logic                     busy,
  output logic                     done,
  output logic [P_ADDR_WIDTH-1:0]  rom_addr,
  input  logic [P_DATA_WIDTH-1:0]  rom_data,
  output logic [P_DATA_WIDTH-1:0]  dout,
  output logic                     dout_valid
);

  state_t                   state_q, state_d;
  logic [P_PHASE_WIDTH-1:0] ftw_q, pofs_q, acc_q;
  logic [P_AMP_WIDTH-1:0]   amp_q;
  logic [P_BURST_WIDTH-1:0] burst_len_q, count_q;
  logic [P_ADDR_WIDTH-1:0]  rom_addr_q;
  logic                     v0_q, v1_q, done_q, done_d;
  logic                     load, issue, last_issue;

  logic [P_PHASE_WIDTH-1:0] phase_sum;
  logic                     unused_phase_lsbs;

  assign phase_sum         = acc_q + pofs_q;
  assign unused_phase_lsbs = ^phase_sum[P_PHASE_WIDTH-P_ADDR_WIDTH-1:0];

  // count_q holds the number of addresses already issued; the edge on which
  // count_q + 1 reaches the burst length issues the final one.
  assign last_issue = (burst_len_q != '0) && ((count_q + 1'b1) == burst_len_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = (cfg_burst_len == P_BURST_WIDTH'(1)) ? DRAIN : RUN;
        end
      end
      RUN: begin
        // A final burst issue takes precedence over a coincident stop so the
        // burst still completes with its full sample count.
        if (last_issue) begin
          issue   = 1'b1;
          state_d = DRAIN;
        end else if (stop) begin
          state_d = DRAIN;
        end else begin
          issue = 1'b1;
        end
      end
      DRAIN: begin
        if (!v0_q && !v1_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q != IDLE);
    // The last sample is in the ROM-data stage with nothing behind it; it
    // reaches dout on the same edge that registers done.
    done_d = (state_q == DRAIN) && v1_q && !v0_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ftw_q       <= '0;
      pofs_q      <= '0;
      amp_q       <= '0;
      burst_len_q <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      rom_addr_q  <= '0;
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      v0_q   <= load | issue;
      v1_q   <= v0_q;
      done_q <= done_d;
      if (load) begin
        ftw_q       <= cfg_ftw;
        pofs_q      <= cfg_pofs;
        amp_q       <= cfg_amp;
        burst_len_q <= cfg_burst_len;
        rom_addr_q  <= cfg_pofs[P_PHASE_WIDTH-1 -: P_ADDR_WIDTH];
        acc_q       <= cfg_ftw;
        count_q     <= P_BURST_WIDTH'(1);
      end else if (issue) begin
        rom_addr_q <= phase_sum[P_PHASE_WIDTH-1 -: P_ADDR_WIDTH];
        acc_q      <= acc_q + ftw_q;
        count_q    <= count_q + 1'b1;
      end
    end
  end

  awg_amp_scale #(
    .P_DATA_WIDTH (P_DATA_WIDTH),
    .P_AMP_WIDTH  (P_AMP_WIDTH)
  ) u_amp_scale (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .data_i  (rom_data),
    .valid_i (v1_q),
    .amp_i   (amp_q),
    .data_o  (dout),
    .valid_o (dout_valid)
  );

  assign rom_addr = rom_addr_q;
  assign done     = done_q;

endmodule

// File: tb/tb_awg_dds_phase_gen.sv
// tb/tb_awg_dds_phase_gen.sv - self-checking bench for awg_dds_phase_gen
module tb_awg_dds_phase_gen;

  logic        clk;
  logic        rst_n;
  logic [31:0] cfg_ftw;
  logic [31:0] cfg_pofs;
  logic [7:0]  cfg_amp;
  logic [15:0] cfg_burst_len;
  logic        start;
  logic        stop;
  logic        busy;
  logic        done;
  logic [7:0]  rom_addr;
  logic [7:0]  rom_data;
  logic [7:0]  dout;
  logic        dout_valid;

  logic [7:0]  rom_mem [256];

  int checks = 0;
  int errors = 0;

  awg_dds_phase_gen dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_ftw       (cfg_ftw),
    .cfg_pofs      (cfg_pofs),
    .cfg_amp       (cfg_amp),
    .cfg_burst_len (cfg_burst_len),
    .start         (start),
    .stop          (stop),
    .busy          (busy),
    .done          (done),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .dout          (dout),
    .dout_valid    (dout_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waveform ROM with one cycle of read latency
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rom_identity();
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'(i);
  endtask

  task automatic rom_fill(input logic [7:0] v);
    for (int i = 0; i < 256; i++) rom_mem[i] = v;
  endtask

  task automatic rom_random();
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'($urandom);
  endtask

  // Sample n addresses phase (n*ftw + pofs) mod 2^32; ROM index is phase / 2^24.
  function automatic int model_addr(input int n, input logic [31:0] ftw, input logic [31:0] pofs);
    longint ph;
    ph = (longint'(n) * longint'(ftw) + longint'(pofs)) % 64'h1_0000_0000;
    return int'(ph / 64'h100_0000);
  endfunction

  // floor(sample * amp / 256), reduced to 8 bits
  function automatic int model_dout(input logic [7:0] sample, input logic [7:0] amp);
    int p, q;
    p = int'($signed(sample)) * int'(amp);
    q = p / 256;
    if (p < 0 && (p % 256) != 0) q = q - 1;
    return q & 255;
  endfunction

  // Cycle 0 is the cycle in which start is held high. Sample k is issued at
  // the end of cycle k, its address is visible in cycle k+1 and its output in
  // cycle k+3. stop_at/restart_at/chg_at name the cycle in which that
  // stimulus is applied (0 = never).
  task automatic run_case(input logic [31:0] ftw, input logic [31:0] pofs,
                          input logic [7:0] amp, input logic [15:0] blen,
                          input int stop_at, input int restart_at, input int chg_at,
                          input bit stop_with_start);
    int n_exp;
    int addr_exp [$];
    int dout_exp [$];
    n_exp = (blen == 16'd0) ? stop_at : int'(blen);
    for (int n = 0; n < n_exp; n++) begin
      addr_exp.push_back(model_addr(n, ftw, pofs));
      dout_exp.push_back(model_dout(rom_mem[model_addr(n, ftw, pofs)], amp));
    end
    cfg_ftw       = ftw;
    cfg_pofs      = pofs;
    cfg_amp       = amp;
    cfg_burst_len = blen;
    start         = 1'b1;
    stop          = stop_with_start;
    for (int c = 0; c <= n_exp + 3; c++) begin
      @(negedge clk);
      check("busy", 32'(busy), 32'(c >= 1 && c <= n_exp + 2));
      check("dout_valid", 32'(dout_valid), 32'(c >= 3 && c <= n_exp + 2));
      check("done", 32'(done), 32'(c == n_exp + 2));
      if (c >= 1 && c <= n_exp) check("rom_addr", 32'(rom_addr), 32'(addr_exp[c-1]));
      if (c >= 3 && c <= n_exp + 2) check("dout", 32'(dout), 32'(dout_exp[c-3]));
      @(posedge clk);
      #1;
      start = (c + 1 == restart_at);
      stop  = (stop_at != 0) && (c + 1 == stop_at);
      if (c + 1 == chg_at) begin
        cfg_ftw       = $urandom;
        cfg_pofs      = $urandom;
        cfg_amp       = 8'($urandom);
        cfg_burst_len = 16'($urandom_range(1, 3));
      end
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    start         = 1'b0;
    stop          = 1'b0;
    cfg_ftw       = '0;
    cfg_pofs      = '0;
    cfg_amp       = '0;
    cfg_burst_len = '0;
    rom_identity();

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_dout_valid", 32'(dout_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Burst of 4, identity ROM, amp 128: addresses 0..3, dout 0,0,1,1
    run_case(32'h0100_0000, 32'h0, 8'd128, 16'd4, 0, 0, 0, 1'b0);

    // Phase wrap with offset: addresses 64,192,64,192
    run_case(32'h8000_0000, 32'h4000_0000, 8'($urandom), 16'd4, 0, 0, 0, 1'b0);

    // Most negative sample at full and zero amplitude
    rom_fill(8'h80);
    run_case(32'h0, $urandom, 8'd255, 16'd1, 0, 0, 0, 1'b0);
    run_case(32'h0, $urandom, 8'd0, 16'd1, 0, 0, 0, 1'b0);

    // Continuous play stopped five cycles after start
    rom_identity();
    run_case($urandom, $urandom, 8'($urandom), 16'd0, 5, 0, 0, 1'b0);

    // Restart and configuration changes while busy are ignored
    run_case($urandom, $urandom, 8'($urandom), 16'd6, 0, 3, 2, 1'b0);

    // start and stop together in IDLE: start wins; stop in DRAIN ignored
    run_case($urandom, $urandom, 8'($urandom), 16'd3, 4, 0, 0, 1'b1);

    // Reset two cycles into a burst of 8
    cfg_ftw       = 32'h0300_0000;
    cfg_pofs      = 32'h2000_0000;
    cfg_amp       = 8'd200;
    cfg_burst_len = 16'd8;
    start         = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_rom_addr", 32'(rom_addr), 32'd0);
    check("midrst_dout", 32'(dout), 32'd0);
    check("midrst_dout_valid", 32'(dout_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_quiet", 32'({busy, dout_valid, done}), 32'd0);
    end
    @(posedge clk);
    #1;
    run_case(32'h0300_0000, 32'h2000_0000, 8'd200, 16'd8, 0, 0, 0, 1'b0);

    // Randomized configurations against the reference model
    for (int t = 0; t < 12; t++) begin
      logic [15:0] blen;
      int          s_at, r_at, c_at, n_run;
      rom_random();
      blen = 16'($urandom_range(0, 10));
      if (blen == 16'd0) begin
        s_at  = $urandom_range(1, 12);
        n_run = s_at;
      end else begin
        // stop only lands in DRAIN, where it must be ignored
        s_at  = ($urandom_range(0, 1) == 1) ? int'(blen) + $urandom_range(0, 2) : 0;
        n_run = int'(blen);
      end
      r_at = ($urandom_range(0, 1) == 1) ? $urandom_range(1, n_run + 2) : 0;
      c_at = ($urandom_range(0, 1) == 1) ? $urandom_range(1, n_run + 2) : 0;
      run_case($urandom, $urandom, 8'($urandom), blen, s_at, r_at, c_at,
               1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
